// File: rtl/serial_in_parallel_out_if.sv
// Serial receive bus: bit stream plus enable in, held parallel word with
// valid/ready handshake and error flags out.
interface serial_in_parallel_out_if #(
    parameter int WIDTH = 4
);
    logic             in;
    logic             en;
    logic             ready;
    logic [WIDTH-1:0] pout;
    logic             valid;
    logic             ovr;
    logic             ferr;

    modport master (
        output in, en, ready,
        input  pout, valid, ovr, ferr
    );

    modport slave (
        input  in, en, ready,
        output pout, valid, ovr, ferr
    );
endinterface

// File: rtl/serial_in_parallel_out.sv
// Serial-to-parallel receiver: assembles WIDTH-bit words from an enabled bit
// stream and holds them behind a valid/ready handshake with overrun/abort flags.
module serial_in_parallel_out #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic                    clk,
    input logic                    clear,
    serial_in_parallel_out_if.slave bus
);
    localparam int              CW    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   LAST  = CW'(WIDTH - 1);
    localparam logic [0:0]      IDLE  = 1'b0;
    localparam logic [0:0]      SHIFT = 1'b1;

    logic [0:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shnext;
    logic [WIDTH-1:0] pout_q;
    logic             valid_q;
    logic             ovr_q;
    logic             ferr_q;
    logic             done;

    always_comb begin
        shnext = shreg;
        if (MSB_FIRST) begin
            shnext = {shreg[WIDTH-2:0], bus.in};
        end else begin
            shnext = {bus.in, shreg[WIDTH-1:1]};
        end
    end

    // The last bit of a word is sampled only from SHIFT; IDLE always takes bit 0.
    assign done = bus.en && (state == SHIFT) && (cnt == LAST);

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state   <= IDLE;
            cnt     <= '0;
            shreg   <= '0;
            pout_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            ferr_q <= 1'b0;

            if (bus.en) begin
                shreg <= shnext;
                state <= SHIFT;
                cnt   <= done ? '0 : cnt + CW'(1);
            end else begin
                state <= IDLE;
                cnt   <= '0;
                if ((state == SHIFT) && (cnt != '0)) begin
                    ferr_q <= 1'b1;
                end
            end

            // A completion may replace a word being accepted on the same edge;
            // otherwise a completion against an unaccepted word is dropped.
            if (done && (!valid_q || bus.ready)) begin
                pout_q  <= shnext;
                valid_q <= 1'b1;
            end else if (done) begin
                ovr_q <= 1'b1;
            end else if (valid_q && bus.ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.pout  = pout_q;
    assign bus.valid = valid_q;
    assign bus.ovr   = ovr_q;
    assign bus.ferr  = ferr_q;
endmodule

// File: tb/tb_serial_in_parallel_out.sv
// Directed bench for serial_in_parallel_out: MSB-first and LSB-first instances
// driven with the same stimulus, checked against hand-computed words.
module tb_serial_in_parallel_out;
    logic clk;
    logic clear;
    int   passed;
    int   total;

    serial_in_parallel_out_if #(.WIDTH(4)) if0 ();
    serial_in_parallel_out_if #(.WIDTH(4)) if1 ();

    serial_in_parallel_out #(.WIDTH(4), .MSB_FIRST(1'b1)) dut0 (
        .clk   (clk),
        .clear (clear),
        .bus   (if0.slave)
    );

    serial_in_parallel_out #(.WIDTH(4), .MSB_FIRST(1'b0)) dut1 (
        .clk   (clk),
        .clear (clear),
        .bus   (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive on the falling edge, let one rising edge act, sample 1 ns after it.
    task automatic step(input logic e, input logic b, input logic r);
        @(negedge clk);
        if0.en = e; if0.in = b; if0.ready = r;
        if1.en = e; if1.in = b; if1.ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        if0.en = 1'b0; if1.en = 1'b0;
        #1 clear = 1'b1;
        #1 clear = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] bits;
        clear = 1'b1;
        #1;
        total++; if (if0.pout !== 4'b0000) $display("FAIL reset_pout got %b want 0000", if0.pout); else passed++;
        total++; if (if0.valid !== 1'b0) $display("FAIL reset_valid got %b want 0", if0.valid); else passed++;
        total++; if (if0.ovr !== 1'b0) $display("FAIL reset_ovr got %b want 0", if0.ovr); else passed++;
        total++; if (if0.ferr !== 1'b0) $display("FAIL reset_ferr got %b want 0", if0.ferr); else passed++;
        @(negedge clk);
        clear = 1'b0;
        // Load a word, start a second one, then clear asynchronously mid-frame.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        if0.en = 1'b0; if1.en = 1'b0;
        #1 clear = 1'b1;
        #1;
        total++; if (if0.valid !== 1'b0) $display("FAIL async_clear_valid got %b want 0", if0.valid); else passed++;
        total++; if (if0.pout !== 4'b0000) $display("FAIL async_clear_pout got %b want 0000", if0.pout); else passed++;
        clear = 1'b0;
        bits = 4'b0110;
        for (int i = 3; i >= 0; i--) begin
            step(1'b1, bits[i], 1'b0);
            total++; if (if0.ferr !== 1'b0) $display("FAIL reset_noferr got %b want 0 at bit %0d", if0.ferr, 3 - i); else passed++;
        end
        total++; if (if0.pout !== 4'b0110) $display("FAIL reset_word got %b want 0110", if0.pout); else passed++;
        total++; if (if0.valid !== 1'b1) $display("FAIL reset_word_valid got %b want 1", if0.valid); else passed++;
    endtask

    task automatic test_basic();
        logic [3:0] bits;
        step(1'b0, 1'b0, 1'b1);
        total++; if (if0.valid !== 1'b0) $display("FAIL basic_consume0 got %b want 0", if0.valid); else passed++;
        bits = 4'b1010;
        for (int i = 3; i >= 0; i--) step(1'b1, bits[i], 1'b0);
        total++; if (if0.pout !== 4'b1010) $display("FAIL basic_word got %b want 1010", if0.pout); else passed++;
        total++; if (if0.valid !== 1'b1) $display("FAIL basic_valid got %b want 1", if0.valid); else passed++;
        step(1'b0, 1'b0, 1'b0);
        total++; if (if0.valid !== 1'b1) $display("FAIL basic_hold_valid got %b want 1", if0.valid); else passed++;
        step(1'b0, 1'b0, 1'b1);
        total++; if (if0.valid !== 1'b0) $display("FAIL basic_accept got %b want 0", if0.valid); else passed++;
        total++; if (if0.pout !== 4'b1010) $display("FAIL basic_pout_held got %b want 1010", if0.pout); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] bits;
        bits = 8'b1100_0011;
        for (int i = 7; i >= 0; i--) begin
            step(1'b1, bits[i], (i == 0) ? 1'b1 : 1'b0);
            if (i == 4) begin
                total++; if (if0.pout !== 4'b1100) $display("FAIL b2b_first got %b want 1100", if0.pout); else passed++;
            end
            if (i < 4) begin
                total++; if (if0.valid !== 1'b1) $display("FAIL b2b_valid got %b want 1 at bit %0d", if0.valid, 7 - i); else passed++;
            end
        end
        total++; if (if0.pout !== 4'b0011) $display("FAIL b2b_second got %b want 0011", if0.pout); else passed++;
        total++; if (if0.ovr !== 1'b0) $display("FAIL b2b_ovr got %b want 0", if0.ovr); else passed++;
        step(1'b0, 1'b0, 1'b1);
        total++; if (if0.valid !== 1'b0) $display("FAIL b2b_drain got %b want 0", if0.valid); else passed++;
        total++; if (if0.ferr !== 1'b0) $display("FAIL b2b_idle_ferr got %b want 0", if0.ferr); else passed++;
    endtask

    task automatic test_overrun();
        logic [7:0] bits;
        bits = 8'b1001_0110;
        for (int i = 7; i >= 0; i--) begin
            step(1'b1, bits[i], 1'b0);
            if (i == 4) begin
                total++; if (if0.pout !== 4'b1001) $display("FAIL ovr_first got %b want 1001", if0.pout); else passed++;
                total++; if (if0.ovr !== 1'b0) $display("FAIL ovr_early got %b want 0", if0.ovr); else passed++;
            end
        end
        total++; if (if0.pout !== 4'b1001) $display("FAIL ovr_pout_kept got %b want 1001", if0.pout); else passed++;
        total++; if (if0.valid !== 1'b1) $display("FAIL ovr_valid got %b want 1", if0.valid); else passed++;
        total++; if (if0.ovr !== 1'b1) $display("FAIL ovr_set got %b want 1", if0.ovr); else passed++;
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        total++; if (if0.valid !== 1'b0) $display("FAIL ovr_accept got %b want 0", if0.valid); else passed++;
        total++; if (if0.ovr !== 1'b1) $display("FAIL ovr_sticky got %b want 1", if0.ovr); else passed++;
        pulse_clear();
        total++; if (if0.ovr !== 1'b0) $display("FAIL ovr_cleared got %b want 0", if0.ovr); else passed++;
    endtask

    task automatic test_abort();
        logic [3:0] bits;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        total++; if (if0.ferr !== 1'b0) $display("FAIL abort_preferr got %b want 0", if0.ferr); else passed++;
        step(1'b0, 1'b0, 1'b0);
        total++; if (if0.ferr !== 1'b1) $display("FAIL abort_ferr got %b want 1", if0.ferr); else passed++;
        total++; if (if0.valid !== 1'b1) $display("FAIL abort_valid got %b want 1", if0.valid); else passed++;
        total++; if (if0.pout !== 4'b1111) $display("FAIL abort_pout got %b want 1111", if0.pout); else passed++;
        step(1'b0, 1'b0, 1'b1);
        total++; if (if0.ferr !== 1'b0) $display("FAIL abort_ferr_width got %b want 0", if0.ferr); else passed++;
        bits = 4'b0001;
        for (int i = 3; i >= 0; i--) begin
            step(1'b1, bits[i], 1'b0);
            if (i == 2) begin
                total++; if (if0.valid !== 1'b0) $display("FAIL abort_restart got %b want 0", if0.valid); else passed++;
            end
        end
        total++; if (if0.pout !== 4'b0001) $display("FAIL abort_word got %b want 0001", if0.pout); else passed++;
        total++; if (if0.valid !== 1'b1) $display("FAIL abort_word_valid got %b want 1", if0.valid); else passed++;
        total++; if (if0.ovr !== 1'b0) $display("FAIL abort_ovr got %b want 0", if0.ovr); else passed++;
    endtask

    task automatic test_lsb_first();
        logic [3:0] bits;
        pulse_clear();
        bits = 4'b1000;
        for (int i = 3; i >= 0; i--) step(1'b1, bits[i], 1'b0);
        total++; if (if1.pout !== 4'b0001) $display("FAIL lsb_word got %b want 0001", if1.pout); else passed++;
        total++; if (if1.valid !== 1'b1) $display("FAIL lsb_valid got %b want 1", if1.valid); else passed++;
        total++; if (if0.pout !== 4'b1000) $display("FAIL msb_same_stream got %b want 1000", if0.pout); else passed++;
        step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        passed = 0;
        total  = 0;
        clear  = 1'b0;
        if0.en = 1'b0; if0.in = 1'b0; if0.ready = 1'b0;
        if1.en = 1'b0; if1.in = 1'b0; if1.ready = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_overrun();
        test_abort();
        test_lsb_first();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/serial_in_parallel_out.md
# serial_in_parallel_out

Serial-to-parallel receiver: samples a serial bit stream one bit per clock while `en` is high and assembles it into `WIDTH`-bit words. It is the receive end of the team's parallel-in/serial-out shifter. It accepts MSB-first (default) or LSB-first streams and presents each completed word on a held parallel output with a valid/ready handshake. It detects overrun and aborted (short) frames.

## Interface
- `WIDTH`, 4, word length in bits; legal range ≥ 2.
- `MSB_FIRST`, 1, 1 = first received bit lands in `pout[WIDTH-1]`; 0 = first bit lands in `pout[0]`.

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `clear`  in  1  asynchronous, active-high reset.
- `in`  in  1  serial data bit, sampled when `en`=1.
- `en`  in  1  frame enable; high for every bit of a word.
- `ready`  in  1  consumer accepts the held word.
- `pout`  out  WIDTH  last completed word, held until replaced.
- `valid`  out  1  `pout` holds an unaccepted word.
- `ovr`  out  1  sticky overrun flag.
- `ferr`  out  1  one-cycle pulse: frame aborted with a partial word.

## Operation
- Reset (`clear`=1, asynchronous, any time):
  - shift register = 0, bit counter = 0, `pout` = 0, `valid` = 0, `ovr` = 0, `ferr` = 0.
  - FSM = IDLE.
  - A partial word in progress is discarded; no `ferr` is raised.
- FSM states:
  - IDLE: counter = 0. An edge with `en`=1 samples bit 0, sets counter = 1, and moves to SHIFT.
  - SHIFT: each edge with `en`=1 samples one bit and increments the counter.
    - On the edge that samples bit WIDTH-1, the assembled word is transferred to `pout`, the counter returns to 0, and the FSM stays in SHIFT if `en` was 1. The next word starts on the next edge, with no gap cycle.
    - An edge with `en`=0 while counter ≠ 0 aborts the frame: partial bits are discarded, the counter goes to 0, `ferr`=1 for exactly one cycle, and the FSM moves to IDLE.
    - An edge with `en`=0 while counter = 0 moves the FSM to IDLE with no `ferr`.
- Bit placement:
  - `MSB_FIRST`=1: shift left, new bit enters at LSB. Bits 1,0,1,0 give `pout`=4'b1010.
  - `MSB_FIRST`=0: shift right, new bit enters at MSB. Bits 1,0,1,0 give `pout`=4'b0101.
- Output handshake:
  - A word completion sets `valid`=1.
  - An edge with `valid`=1 and `ready`=1 consumes the word, and `valid` falls at that edge.
  - `pout` keeps its value after consumption; it only changes on a word completion.
- Simultaneous events:
  - Completion with `valid`=0: load `pout`, set `valid`.
  - Completion with `valid`=1 and `ready`=1 on the same edge: load the new word, `valid` stays 1, no overrun.
  - Completion with `valid`=1 and `ready`=0: the new word is dropped, `pout` and `valid` are unchanged, and `ovr` is set. `ovr` stays set until `clear`.
- `ready` while `valid`=0 has no effect.

## Timing
- `in` is sampled at the rising edge; it must be stable for setup/hold around that edge.
- Latency: `pout`/`valid` update at the same edge that samples the last bit, so they are visible in the following cycle.
- Throughput: one word every WIDTH cycles with `en` held high. The consumer must assert `ready` within WIDTH cycles of `valid` rising to avoid overrun.
- `ferr` is high for the single cycle after the aborting edge.
- `ovr` rises in the cycle after the dropping edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset/idle: assert `clear` mid-frame after 2 bits, release, then send 4 bits 0,1,1,0 (`MSB_FIRST`=1) -> `pout`=4'b0110 and `valid`=1 one cycle after the 4th edge; no `ferr` at any point.
- Basic word: with `WIDTH`=4, `MSB_FIRST`=1, `ready` tied to 0, send 1,0,1,0 -> `pout`=4'b1010, `valid`=1. Then pulse `ready` for one cycle -> `valid`=0, `pout` still 4'b1010.
- Back-to-back streaming: hold `en` high for 8 cycles with bits 1,1,0,0,0,0,1,1 and `ready`=1 on cycle 8 -> `pout`=4'b1100 then 4'b0011; `valid` stays high across the same-edge accept/complete; `ovr`=0.
- Overrun: `ready`=0, send two words 4'b1001 then 4'b0110 -> `pout` stays 4'b1001, `valid`=1, `ovr`=1; `ovr` remains 1 until `clear`.
- Aborted frame: send bits 1,1 then drop `en` for one cycle -> `ferr`=1 for exactly one cycle, `valid` unchanged. Then send 0,0,0,1 -> `pout`=4'b0001.
- LSB-first: with `MSB_FIRST`=0, send 1,0,0,0 -> `pout`=4'b0001.
